ledseq_n: RTL
=============

# ledseq_n

Parametrised LED pattern sequencer driving NLED LEDs from a free-running prescaler. It has four selectable animation modes: bounce, shift-up, shift-down and bar-fill. A one-cycle NEXT pulse, normally from the board's debounce block, advances the mode; a PAUSE level freezes the animation. It sits between the button debouncer and the LED pins and replaces fixed-width, fixed-mode blink logic in the top level.

## Interface

Parameters:
- NLED, 4: number of LEDs. Legal range 2..16.
- PRESCALE_W, 23: prescaler width. With the speed feature absent, one animation step occurs every 2^PRESCALE_W clocks. Must be ≥4.

Ports:
- CLK, input, 1: clock.
- RST, input, 1: synchronous, active-high reset.
- NEXT, input, 1: one-cycle pulse; advance to the next mode.
- PAUSE, input, 1: level; while high, the animation holds.
- SPD, input, 1: one-cycle pulse; cycle the speed setting. Present only with LEDSEQ_SPEED_EN.
- LED, output, NLED: LED drive, active-high; bit 0 is the rightmost LED.
- MODE, output, 2: current mode.
- TICK, output, 1: one-cycle strobe marking an animation step.

## Operation

- Prescaler counter `pre` is PRESCALE_W bits wide.
  - It increments every cycle while PAUSE=0 and holds while PAUSE=1.
  - TICK=1 when PAUSE=0 and the low K bits of `pre` are all ones.
  - K=PRESCALE_W without the speed feature (see Configuration for K with it).
- State registers:
  - `mode`: 2 bits.
  - `pos`: $clog2(NLED+1) bits.
  - `dir`: 1 bit, 0=up, 1=down.
- Mode 0, bounce:
  - On TICK with dir=0: pos+1. When pos reaches NLED-1, set dir=1 in the same update.
  - On TICK with dir=1: pos-1. When pos reaches 0, set dir=0.
  - LED = 1<<pos. Sequence period is 2·NLED-2 ticks, with no repeated end positions.
- Mode 1, shift-up: on TICK, pos = (pos==NLED-1) ? 0 : pos+1. LED = 1<<pos.
- Mode 2, shift-down: pos counts as in mode 1. LED = 1<<(NLED-1-pos).
- Mode 3, bar-fill: on TICK, pos = (pos==NLED) ? 0 : pos+1. LED = (1<<pos)-1, giving 0, 1, 3, …, all-ones, then 0.
- LED is a pure combinational decode of the registered mode and pos. No LED bit is ever X; decode defaults to all zeros.
- NEXT handling:
  - mode = mode+1, wrapping 3→0; all four modes are reachable.
  - pos=0, dir=0, pre=0.
  - The new pattern's first frame appears in the cycle after NEXT.
- Priority: RST > NEXT > TICK. If NEXT and TICK coincide, the step is dropped and NEXT applies.
- A NEXT held high for N cycles advances N modes. Upstream must deliver single-cycle pulses.
- NEXT is honoured while PAUSE=1: the mode changes and the animation stays frozen at pos=0.

## Timing

- Reset values: mode=0, pos=0, dir=0, pre=0, speed=0.
  - Outputs after reset: LED = {(NLED-1){0},1}, MODE=0, TICK=0.
- With PAUSE=0 and no NEXT, the first TICK after reset occurs in cycle 2^K-1, counting the first post-reset cycle as 0.
  - TICK repeats every 2^K cycles thereafter.
- pos, dir and LED update in the cycle after TICK is high, so latency is 1 clock.
- MODE and LED reflect NEXT one clock after the pulse.
- RST asserted mid-animation returns all state to reset values on the next edge, regardless of NEXT, PAUSE or SPD.
- Deasserting PAUSE resumes from the held pre value; no tick is lost or duplicated.

## Configuration

- LEDSEQ_SPEED_EN defined:
  - Port SPD exists, along with a 2-bit `speed` register (reset 0).
  - SPD pulse: speed = speed+1, wrapping 3→0, and pre=0.
  - K = PRESCALE_W - speed, so each speed step doubles the step rate.
  - NEXT does not change speed.
  - If SPD and NEXT coincide, both take effect.
- LEDSEQ_SPEED_EN undefined: no SPD port, no speed register, and K=PRESCALE_W.

## Test plan

All scenarios use NLED=4 and PRESCALE_W=2, so a TICK occurs every 4 cycles.

- Reset, then run 40 ticks in mode 0 → LED sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, …; TICK spacing is exactly 4 cycles.
- Three NEXT pulses, then one more → MODE goes 1, 2, 3, 0.
  - Mode 1 shows 0001→0010→0100→1000→0001.
  - Mode 2 shows 1000→0100→0010→0001.
  - Mode 3 shows 0000→0001→0011→0111→1111→0000.
- NEXT in the same cycle as TICK while in mode 1 at pos=2 → next cycle MODE=2, LED=1000, and no step is applied.
- PAUSE high for 20 cycles in the middle of mode 0 → LED and pre are unchanged and TICK=0 throughout. After PAUSE drops, the next TICK comes 4-(pre+1) cycles later.
- RST asserted in mode 3 with LED=0111 → next cycle LED=0001 and MODE=0. Repeat the check with NLED=5 and the bounce period equals 8 ticks.
- With LEDSEQ_SPEED_EN defined and PRESCALE_W=4, apply SPD pulses 0→1→2→3→0 → TICK period is 16, 8, 4, 2, then 16 cycles.

Source files
------------

// File: rtl/ledseq_n.sv
// LED pattern sequencer: bounce, shift-up, shift-down and bar-fill animations stepped by a prescaler.
// Define LEDSEQ_SPEED_EN to add the SPD input and a 2-bit speed register that shortens the step period.
module ledseq_n #(
    parameter int NLED       = 4,
    parameter int PRESCALE_W = 23
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            NEXT,
    input  logic            PAUSE,
`ifdef LEDSEQ_SPEED_EN
    input  logic            SPD,
`endif
    output logic [NLED-1:0] LED,
    output logic [1:0]      MODE,
    output logic            TICK
);

    localparam int            PW       = $clog2(NLED + 1);
    localparam logic [PW-1:0] POS_LAST = PW'(NLED - 1);
    localparam logic [PW-1:0] POS_FULL = PW'(NLED);

    typedef enum logic [1:0] {
        MODE_BOUNCE   = 2'd0,
        MODE_SHIFT_UP = 2'd1,
        MODE_SHIFT_DN = 2'd2,
        MODE_BAR      = 2'd3
    } mode_e;

    mode_e                 mode_q, mode_d;
    logic [PW-1:0]         pos_q, pos_d;
    logic                  dir_q, dir_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [PRESCALE_W-1:0] tick_mask;
    logic                  restart;
    logic                  tick;

`ifdef LEDSEQ_SPEED_EN
    logic [1:0] speed_q, speed_d;

    // Each speed step drops one prescaler bit from the tick compare, doubling the rate.
    assign tick_mask = {PRESCALE_W{1'b1}} >> speed_q;
    assign restart   = NEXT | SPD;
    assign speed_d   = SPD ? speed_q + 2'd1 : speed_q;

    always_ff @(posedge CLK) begin
        if (RST) speed_q <= 2'd0;
        else     speed_q <= speed_d;
    end
`else
    assign tick_mask = {PRESCALE_W{1'b1}};
    assign restart   = NEXT;
`endif

    assign tick = !PAUSE && ((pre_q & tick_mask) == tick_mask);

    always_comb begin
        pre_d  = pre_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        if (restart)     pre_d = '0;
        else if (!PAUSE) pre_d = pre_q + PRESCALE_W'(1);
        // A coincident tick is dropped so the new mode always starts from its first frame.
        if (NEXT) begin
            mode_d = mode_e'(mode_q + 2'd1);
            pos_d  = '0;
            dir_d  = 1'b0;
        end else if (tick) begin
            case (mode_q)
                MODE_BOUNCE: begin
                    if (!dir_q) begin
                        pos_d = pos_q + PW'(1);
                        if (pos_q + PW'(1) == POS_LAST) dir_d = 1'b1;
                    end else begin
                        pos_d = pos_q - PW'(1);
                        if (pos_q == PW'(1)) dir_d = 1'b0;
                    end
                end
                MODE_SHIFT_UP, MODE_SHIFT_DN: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
                MODE_BAR:                     pos_d = (pos_q == POS_FULL) ? '0 : pos_q + PW'(1);
                default:                      pos_d = pos_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q <= MODE_BOUNCE;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            pre_q  <= '0;
        end else begin
            mode_q <= mode_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            pre_q  <= pre_d;
        end
    end

    // Per-bit decode keeps every LED defined even for pos values a mode never reaches.
    always_comb begin
        LED = '0;
        for (int i = 0; i < NLED; i++) begin
            case (mode_q)
                MODE_BOUNCE, MODE_SHIFT_UP: LED[i] = (pos_q == PW'(i));
                MODE_SHIFT_DN:              LED[i] = (pos_q == PW'(NLED - 1 - i));
                MODE_BAR:                   LED[i] = (PW'(i) < pos_q);
                default:                    LED[i] = 1'b0;
            endcase
        end
    end

    assign MODE = mode_q;
    assign TICK = tick;

endmodule
